// File: rtl/layer_priority_scheduler.sv
// ----------------------------------------------------------------------------
// layer_priority_scheduler
//
// Runtime-configurable priority arbiter for the VGA object layers. Each pixel
// clock, the enabled, requesting, non-transparent layer with the lowest
// priority value wins (ties go to the lower layer index), and its RGB332 value
// is registered. When no layer wins, the background colour is shown.
// Priority/enable writes land in a shadow table, which is copied into the
// active table on startOfFrame, so a frame never mixes two priority orders.
//
// Optional feature macro: LAYER_PRIO_OVERLAP_COUNT_EN
//   defined   : counts cycles with two or more candidates per frame and
//               reports the previous frame's count on overlapCount
//               (saturating at 16'hFFFF).
//   undefined : no counter is built; overlapCount is tied to 16'h0000.
//
// Ports
//   clk            in   pixel clock
//   resetN         in   asynchronous, active-low reset
//   startOfFrame   in   1-cycle pulse at the first pixel of each frame
//   drawReq        in   per-layer draw request, bit i = layer i
//   layerRGB       in   packed RGB332, layer i at [8*i+7:8*i]
//   backGroundRGB  in   fallback colour
//   cfgValid       in   config write request
//   cfgReady       out  config write accept (combinational)
//   cfgLayer       in   layer being configured
//   cfgPrio        in   new priority (0 = highest)
//   cfgEnable      in   new enable for the layer
//   rgbOut         out  arbitrated RGB332, registered
//   winnerLayer    out  winning layer index, registered
//   winnerValid    out  1 = a layer won, 0 = background shown
//   overlapCount   out  overlap pixels counted in the previous frame
// ----------------------------------------------------------------------------
module layer_priority_scheduler #(
    parameter int         NUM_LAYERS      = 8,
    parameter int         IDX_W           = 3,
    parameter logic [7:0] TRANSPARENT_RGB = 8'hFF
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   drawReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [7:0]              backGroundRGB,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [IDX_W-1:0]        cfgLayer,
    input  logic [IDX_W-1:0]        cfgPrio,
    input  logic                    cfgEnable,
    output logic [7:0]              rgbOut,
    output logic [IDX_W-1:0]        winnerLayer,
    output logic                    winnerValid,
    output logic [15:0]             overlapCount
);

    // Config handshake: a write transfers on a rising clk edge where
    // cfgValid & cfgReady are both high. The requester must hold cfgLayer,
    // cfgPrio and cfgEnable stable while cfgValid is high and not yet
    // accepted. cfgReady drops only during startOfFrame, so a write never
    // races the shadow-to-active commit.
    assign cfgReady = ~startOfFrame;

    logic                  cfg_accept;
    logic [IDX_W-1:0]      shadow_prio [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] shadow_en;
    logic [IDX_W-1:0]      active_prio [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] active_en;

    assign cfg_accept = cfgValid & cfgReady;

    // Shadow and active tables. Out-of-range layer writes are accepted
    // (handshake completes) but change nothing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_prio[i] <= IDX_W'(i);
                active_prio[i] <= IDX_W'(i);
            end
            shadow_en <= '1;
            active_en <= '1;
        end else begin
            if (cfg_accept && (int'(cfgLayer) < NUM_LAYERS)) begin
                shadow_prio[cfgLayer] <= cfgPrio;
                shadow_en[cfgLayer]   <= cfgEnable;
            end
            if (startOfFrame) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    active_prio[i] <= shadow_prio[i];
                end
                active_en <= shadow_en;
            end
        end
    end

    // Candidate mask and winner search. A strict "less than" keeps the
    // earlier (lower-index) layer on equal priority.
    logic [NUM_LAYERS-1:0] cand;
    logic                  best_found;
    logic [IDX_W-1:0]      best_prio;
    logic [IDX_W-1:0]      best_idx;
    logic [7:0]            best_rgb;

    always_comb begin
        cand       = '0;
        best_found = 1'b0;
        best_prio  = '0;
        best_idx   = '0;
        best_rgb   = backGroundRGB;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            cand[i] = drawReq[i] & active_en[i] &
                      (layerRGB[8*i +: 8] != TRANSPARENT_RGB);
            if (cand[i] && (!best_found || (active_prio[i] < best_prio))) begin
                best_found = 1'b1;
                best_prio  = active_prio[i];
                best_idx   = IDX_W'(i);
                best_rgb   = layerRGB[8*i +: 8];
            end
        end
    end

    // Output register; winnerLayer keeps the last winner while background shows.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgbOut      <= '0;
            winnerLayer <= '0;
            winnerValid <= 1'b0;
        end else begin
            rgbOut      <= best_rgb;
            winnerValid <= best_found;
            if (best_found) begin
                winnerLayer <= best_idx;
            end
        end
    end

`ifdef LAYER_PRIO_OVERLAP_COUNT_EN
    logic        multi_cand;
    logic        seen_one;
    logic [15:0] overlap_cnt;
    logic [15:0] overlap_q;

    always_comb begin
        multi_cand = 1'b0;
        seen_one   = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cand[i]) begin
                if (seen_one) begin
                    multi_cand = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    // The startOfFrame pixel belongs to the new frame, so the counter
    // restarts at 1 rather than 0 when that pixel overlaps.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overlap_cnt <= '0;
            overlap_q   <= '0;
        end else if (startOfFrame) begin
            overlap_q   <= overlap_cnt;
            overlap_cnt <= multi_cand ? 16'd1 : 16'd0;
        end else if (multi_cand && (overlap_cnt != 16'hFFFF)) begin
            overlap_cnt <= overlap_cnt + 16'd1;
        end
    end

    assign overlapCount = overlap_q;
`else
    assign overlapCount = 16'h0000;
`endif

endmodule

// File: tb/tb_layer_priority_scheduler.sv
// ----------------------------------------------------------------------------
// tb_layer_priority_scheduler
//
// Directed bench for layer_priority_scheduler with hand-computed expected
// values. Inputs change 1 time unit after the rising edge; registered
// outputs are sampled 1 time unit after the edge that loads them.
// ----------------------------------------------------------------------------
module tb_layer_priority_scheduler;

    localparam int NL = 8;
    localparam int IW = 3;

    logic          clk;
    logic          resetN;
    logic          startOfFrame;
    logic [NL-1:0] drawReq;
    logic [NL*8-1:0] layerRGB;
    logic [7:0]    backGroundRGB;
    logic          cfgValid;
    logic          cfgReady;
    logic [IW-1:0] cfgLayer;
    logic [IW-1:0] cfgPrio;
    logic          cfgEnable;
    logic [7:0]    rgbOut;
    logic [IW-1:0] winnerLayer;
    logic          winnerValid;
    logic [15:0]   overlapCount;

    int checks = 0;
    int errors = 0;

    layer_priority_scheduler #(
        .NUM_LAYERS(NL),
        .IDX_W(IW),
        .TRANSPARENT_RGB(8'hFF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .drawReq(drawReq),
        .layerRGB(layerRGB),
        .backGroundRGB(backGroundRGB),
        .cfgValid(cfgValid),
        .cfgReady(cfgReady),
        .cfgLayer(cfgLayer),
        .cfgPrio(cfgPrio),
        .cfgEnable(cfgEnable),
        .rgbOut(rgbOut),
        .winnerLayer(winnerLayer),
        .winnerValid(winnerValid),
        .overlapCount(overlapCount)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rgb(input int layer, input logic [7:0] val);
        layerRGB[8*layer +: 8] = val;
    endtask

    task automatic cfg_write(input logic [IW-1:0] layer, input logic [IW-1:0] prio, input logic en);
        cfgValid  = 1'b1;
        cfgLayer  = layer;
        cfgPrio   = prio;
        cfgEnable = en;
        step();
        cfgValid  = 1'b0;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        drawReq       = '0;
        layerRGB      = '0;
        backGroundRGB = 8'h00;
        cfgValid      = 1'b0;
        cfgLayer      = '0;
        cfgPrio       = '0;
        cfgEnable     = 1'b0;

        // reset state
        repeat (2) step();
        check("rst_rgb", 32'(rgbOut), 32'h00);
        check("rst_winner", 32'(winnerLayer), 32'h0);
        check("rst_valid", 32'(winnerValid), 32'h0);
        check("rst_overlap", 32'(overlapCount), 32'h0);
        check("rst_ready", 32'(cfgReady), 32'h1);
        resetN = 1'b1;
        step();

        // T1 identity order: layer1 beats layer2
        drawReq = 8'b0000_0110;
        set_rgb(1, 8'h1C);
        set_rgb(2, 8'hE0);
        step();
        check("t1_rgb", 32'(rgbOut), 32'h1C);
        check("t1_winner", 32'(winnerLayer), 32'h1);
        check("t1_valid", 32'(winnerValid), 32'h1);

        // T2 deferred commit
        cfg_write(3'd2, 3'd0, 1'b1);
        step();
        check("t2_before_sof", 32'(rgbOut), 32'h1C);
        sof_pulse();
        check("t2_sof_pixel_old_table", 32'(rgbOut), 32'h1C);
        step();
        check("t2_after_rgb", 32'(rgbOut), 32'hE0);
        check("t2_after_winner", 32'(winnerLayer), 32'h2);

        // back-to-back writes to one layer: the last one wins
        cfg_write(3'd2, 3'd0, 1'b1);
        cfg_write(3'd2, 3'd2, 1'b1);
        sof_pulse();
        step();
        check("b2b_winner", 32'(winnerLayer), 32'h1);
        check("b2b_rgb", 32'(rgbOut), 32'h1C);

        // T3 tie and disable
        backGroundRGB = 8'h25;
        cfg_write(3'd3, 3'd1, 1'b1);
        cfg_write(3'd5, 3'd1, 1'b1);
        sof_pulse();
        drawReq = 8'b0010_1000;
        set_rgb(3, 8'h40);
        set_rgb(5, 8'h08);
        step();
        check("t3_tie_winner", 32'(winnerLayer), 32'h3);
        check("t3_tie_rgb", 32'(rgbOut), 32'h40);
        cfg_write(3'd3, 3'd1, 1'b0);
        step();
        check("t3_dis3_pending", 32'(winnerLayer), 32'h3);
        sof_pulse();
        step();
        check("t3_dis3_winner", 32'(winnerLayer), 32'h5);
        check("t3_dis3_rgb", 32'(rgbOut), 32'h08);
        cfg_write(3'd5, 3'd1, 1'b0);
        sof_pulse();
        step();
        check("t3_bg_rgb", 32'(rgbOut), 32'h25);
        check("t3_bg_valid", 32'(winnerValid), 32'h0);
        check("t3_bg_winner_hold", 32'(winnerLayer), 32'h5);

        // T4 transparency
        drawReq = 8'b0000_0001;
        set_rgb(0, 8'hFF);
        backGroundRGB = 8'h03;
        step();
        check("t4_rgb", 32'(rgbOut), 32'h03);
        check("t4_valid", 32'(winnerValid), 32'h0);
        set_rgb(0, 8'hFE);
        step();
        check("t4_opaque_rgb", 32'(rgbOut), 32'hFE);
        check("t4_opaque_winner", 32'(winnerLayer), 32'h0);

        // T5 handshake collision: write held across startOfFrame
        drawReq = 8'b0100_0010;
        set_rgb(1, 8'h1C);
        set_rgb(6, 8'h55);
        cfgValid     = 1'b1;
        cfgLayer     = 3'd6;
        cfgPrio      = 3'd0;
        cfgEnable    = 1'b1;
        startOfFrame = 1'b1;
        #1;
        check("t5_ready_low", 32'(cfgReady), 32'h0);
        step();
        startOfFrame = 1'b0;
        #1;
        check("t5_ready_high", 32'(cfgReady), 32'h1);
        step();
        cfgValid = 1'b0;
        check("t5_not_yet_winner", 32'(winnerLayer), 32'h1);
        step();
        check("t5_not_yet_winner2", 32'(winnerLayer), 32'h1);
        sof_pulse();
        step();
        check("t5_active_winner", 32'(winnerLayer), 32'h6);
        check("t5_active_rgb", 32'(rgbOut), 32'h55);

        // reset mid-frame returns the table to identity at once
        cfg_write(3'd0, 3'd7, 1'b1);
        sof_pulse();
        drawReq = 8'b0000_0011;
        set_rgb(0, 8'h11);
        step();
        check("rstmid_pre_winner", 32'(winnerLayer), 32'h1);
        resetN = 1'b0;
        #2;
        check("rstmid_rgb", 32'(rgbOut), 32'h00);
        check("rstmid_valid", 32'(winnerValid), 32'h0);
        step();
        check("rstmid_hold_rgb", 32'(rgbOut), 32'h00);
        resetN = 1'b1;
        step();
        check("rstmid_identity_winner", 32'(winnerLayer), 32'h0);
        check("rstmid_identity_rgb", 32'(rgbOut), 32'h11);

        // T6 overlap count: 37 overlapping pixels inside one frame
        drawReq = '0;
        sof_pulse();
        drawReq = 8'b0000_0011;
        repeat (37) step();
        drawReq = 8'b0000_0001;
        repeat (5) step();
        sof_pulse();
`ifdef LAYER_PRIO_OVERLAP_COUNT_EN
        check("t6_overlap_37", 32'(overlapCount), 32'd37);

        // saturation, with the startOfFrame pixel itself overlapping
        drawReq = 8'b0000_0011;
        repeat (70000) step();
        sof_pulse();
        check("t6_overlap_sat", 32'(overlapCount), 32'hFFFF);
        drawReq = '0;
        repeat (3) step();
        sof_pulse();
        check("t6_sof_pixel_counted", 32'(overlapCount), 32'd1);
`else
        check("t6_overlap_off", 32'(overlapCount), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
